// File: rtl/axis_seq_gen_pkt.sv
// axis_seq_gen_pkt: AXI-Stream geometric/arithmetic sequence source framed into PKT_LEN-beat packets.
// Define GEN_OVF_RESTART_EN to reload SEED on overflow instead of wrapping.
module axis_seq_gen_pkt #(
    parameter int DATA_SIZE = 32,
    parameter int SEED      = 1,
    parameter int BASE      = 3,
    parameter int STEP      = 1,
    parameter int PKT_LEN   = 8
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic                     m00_axis_enable,
    input  logic                     gen_mode,
    input  logic                     gen_restart,
    output logic [DATA_SIZE-1:0]     m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
    output logic                     m00_axis_tvalid,
    input  logic                     m00_axis_tready,
    output logic                     m00_axis_tlast,
    output logic                     gen_ovf,
    output logic [15:0]              gen_pkt_cnt
);
    localparam int W2 = 2 * DATA_SIZE;
    localparam int BW = $clog2(PKT_LEN + 1);
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               r_state, w_state_nxt;
    logic [DATA_SIZE-1:0] r_data, w_adv;
    logic [BW-1:0]        r_beat;
    logic [15:0]          r_cnt;
    logic                 r_mode, r_ovf, r_pend;
    logic [W2-1:0]        w_res;
    logic                 w_ovf, w_xfer, w_end, w_start, w_pend, w_reseed;

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) r_state <= IDLE;
        else                 r_state <= w_state_nxt;
    end

    // Next value is formed at double width so overflow is visible.
    always_comb begin
        w_res       = r_mode ? W2'(r_data) + W2'(STEP) : W2'(r_data) * W2'(BASE);
        w_ovf       = |w_res[W2-1:DATA_SIZE];
`ifdef GEN_OVF_RESTART_EN
        w_adv       = w_ovf ? DATA_SIZE'(SEED) : w_res[DATA_SIZE-1:0];
`else
        w_adv       = w_res[DATA_SIZE-1:0];
`endif
        w_xfer      = (r_state == ACTIVE) && m00_axis_tready;
        w_end       = w_xfer && (r_beat == LAST);
        w_start     = m00_axis_enable && ((r_state == IDLE) || w_end);
        w_pend      = r_pend || gen_restart;
        w_reseed    = w_start && w_pend;
        w_state_nxt = w_start ? ACTIVE : (w_end ? IDLE : r_state);
        m00_axis_tvalid = (r_state == ACTIVE);
        m00_axis_tlast  = (r_state == ACTIVE) && (r_beat == LAST);
        m00_axis_tstrb  = {(DATA_SIZE/8){r_state == ACTIVE}};
        m00_axis_tdata  = r_data;
        gen_ovf         = r_ovf;
        gen_pkt_cnt     = r_cnt;
    end

    // A pending restart wins over any overflow computed on the same edge.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            r_data <= DATA_SIZE'(SEED);
            r_beat <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_ovf  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_pend && !w_start;
            if (w_start) r_mode <= gen_mode;
            if (w_xfer) r_beat <= w_end ? '0 : r_beat + 1'b1;
            if (w_end) r_cnt <= r_cnt + 16'd1;
            if (w_reseed) r_data <= DATA_SIZE'(SEED);
            else if (w_xfer) r_data <= w_adv;
            if (w_reseed) r_ovf <= 1'b0;
            else if (w_xfer && w_ovf) r_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_seq_gen_pkt.sv
// tb_axis_seq_gen_pkt: packet-level reference model feeding a scoreboard; a negedge monitor checks every beat.
module tb_axis_seq_gen_pkt;
    localparam int DW = 8, SEED = 1, BASE = 3, STEP = 5, PL = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          o;
        logic [15:0]   c;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0, restart = 1'b0, tready = 1'b0;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tvalid, tlast, ovf;
    logic [15:0]     cnt;

    int    n_vec = 0, n_err = 0;
    logic  mon_en = 1'b0;
    beat_t q[$];
    logic [DW-1:0] m_val = DW'(SEED);
    logic          m_ovf = 1'b0, m_pend = 1'b0;
    logic [15:0]   m_cnt = '0;

    axis_seq_gen_pkt #(.DATA_SIZE(DW), .SEED(SEED), .BASE(BASE), .STEP(STEP), .PKT_LEN(PL)) dut (
        .m00_axis_aclk(clk), .m00_axis_areset(rst), .m00_axis_enable(en),
        .gen_mode(mode), .gen_restart(restart),
        .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb), .m00_axis_tvalid(tvalid),
        .m00_axis_tready(tready), .m00_axis_tlast(tlast),
        .gen_ovf(ovf), .gen_pkt_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats for n whole packets, straight from the sequence rules.
    task automatic model_push(input logic m, input logic rm, input int n);
        longint r;
        for (int p = 0; p < n; p++) begin
            if (m_pend) begin
                m_val  = DW'(SEED);
                m_ovf  = 1'b0;
                m_pend = 1'b0;
            end
            for (int b = 0; b < PL; b++) begin
                q.push_back('{d: m_val, l: (b == PL - 1), o: m_ovf, c: m_cnt});
                r = m ? longint'(m_val) + STEP : longint'(m_val) * BASE;
                if (r >= (64'd1 << DW)) begin
                    m_ovf = 1'b1;
`ifdef GEN_OVF_RESTART_EN
                    m_val = DW'(SEED);
`else
                    m_val = DW'(r % (64'd1 << DW));
`endif
                end else m_val = DW'(r);
            end
            m_cnt = m_cnt + 16'd1;
            if (p == 0 && rm) m_pend = 1'b1;
        end
    endtask

    // Run n packets: enable is dropped once the final packet is under way.
    task automatic phase(input logic m, input logic ri, input logic rm, input int n);
        int   done = 0, budget = 400;
        logic first = 1'b1, w;
        if (ri) begin
            restart = 1'b1;
            tick();
            restart = 1'b0;
            m_pend  = 1'b1;
        end
        model_push(m, rm, n);
        mode = m;
        en   = 1'b1;
        tick();
        while (done < n && budget > 0) begin
            if (done == n - 1) en = 1'b0;
            restart = first ? rm : 1'b0;
            first   = 1'b0;
            tready  = ($urandom_range(0, 3) != 0);
            w       = tvalid && tready && tlast;
            tick();
            if (w) done++;
            budget--;
        end
        en      = 1'b0;
        restart = 1'b0;
        if (budget == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL phase_timeout: got %0d packets expected %0d", done, n);
        end
        chk("idle_after_pkt", {31'd0, tvalid}, 32'd0);
        chk("pkt_cnt", {16'd0, cnt}, {16'd0, m_cnt});
    endtask

    initial begin : monitor
        beat_t         e;
        logic          stall = 1'b0, p_last = 1'b0;
        logic [DW-1:0] p_data = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("tstrb", {{(32 - DW/8){1'b0}}, tstrb}, tvalid ? {{(32 - DW/8){1'b0}}, {(DW/8){1'b1}}} : 32'd0);
                if (stall) begin
                    chk("hold_valid", {31'd0, tvalid}, 32'd1);
                    chk("hold_data", {{(32 - DW){1'b0}}, tdata}, {{(32 - DW){1'b0}}, p_data});
                    chk("hold_last", {31'd0, tlast}, {31'd0, p_last});
                end
                if (tvalid && tready) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h expected none", tdata);
                    end else begin
                        e = q.pop_front();
                        chk("tdata", {{(32 - DW){1'b0}}, tdata}, {{(32 - DW){1'b0}}, e.d});
                        chk("tlast", {31'd0, tlast}, {31'd0, e.l});
                        chk("gen_ovf", {31'd0, ovf}, {31'd0, e.o});
                        chk("beat_pkt_cnt", {16'd0, cnt}, {16'd0, e.c});
                    end
                end
                stall  = tvalid && !tready;
                p_data = tdata;
                p_last = tlast;
            end else stall = 1'b0;
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", {{(32 - DW){1'b0}}, tdata}, SEED);
        chk("rst_tstrb", {{(32 - DW/8){1'b0}}, tstrb}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();
        phase(1'b0, 1'b0, 1'b0, 2);
        phase(1'b0, 1'b0, 1'b0, 1);
        phase(1'b1, 1'b0, 1'b1, 2);
        phase(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 25; i++)
            phase(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 3)));
        mon_en = 1'b0;
        mode   = 1'b0;
        tready = 1'b1;
        en     = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        chk("midrst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("midrst_tdata", {{(32 - DW){1'b0}}, tdata}, SEED);
        chk("midrst_tlast", {31'd0, tlast}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        chk("midrst_cnt", {16'd0, cnt}, 32'd0);
        rst    = 1'b0;
        m_val  = DW'(SEED);
        m_ovf  = 1'b0;
        m_pend = 1'b0;
        m_cnt  = '0;
        q.delete();
        mon_en = 1'b1;
        tick();
        phase(1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++)
            phase(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 3)));
        tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
